// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding and default geometry for the data-memory responder
package dmem_pkg;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam int DEF_WORD_DEPTH = 36;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h10010000;
    localparam int DEF_LATENCY = 4;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage with one synchronous write port and one synchronous read port, never reset
module dmem_array #(
    parameter int DEPTH = 36,
    parameter int IW = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [IW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [0:DEPTH-1];
    // write and read share one index; the read register holds its value between reads
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
        if (re) rdata <= mem[idx];
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency single-outstanding memory responder with address legality check
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          WORD_DEPTH = DEF_WORD_DEPTH,
    parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
    parameter int          LATENCY    = DEF_LATENCY
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err
);
    localparam int IW = WORD_DEPTH > 1 ? $clog2(WORD_DEPTH) : 1;
    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        c_wen;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        s_wen;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [31:0] off;
    logic        legal;
    logic        to_resp;
    logic        rd_ok;
    logic [31:0] q;
    // with LATENCY=1 the response is formed straight from the inputs on the accepting edge
    assign s_wen   = state == IDLE ? wen : c_wen;
    assign s_addr  = state == IDLE ? addr : c_addr;
    assign s_wdata = state == IDLE ? wdata : c_wdata;
    assign off     = s_addr - BASE_ADDR;
    assign legal   = s_addr[1:0] == 2'b00 && s_addr >= BASE_ADDR && (off >> 2) < 32'(WORD_DEPTH);
    assign to_resp = (state == IDLE && req && LATENCY == 1) || (state == BUSY && cnt == 4'd0);
    assign rdata   = rd_ok ? q : '0;
    dmem_array #(.DEPTH(WORD_DEPTH), .IW(IW)) u_array (
        .clk   (clk),
        .we    (to_resp && legal && s_wen),
        .re    (to_resp && legal && !s_wen),
        .idx   (off[IW+1:2]),
        .wdata (s_wdata),
        .rdata (q)
    );
    // IDLE -> BUSY (or RESP) on req, BUSY counts down, RESP lasts one cycle; outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            c_wen   <= 1'b0;
            c_addr  <= '0;
            c_wdata <= '0;
            ready   <= 1'b0;
            err     <= 1'b0;
            rd_ok   <= 1'b0;
        end else begin
            ready <= to_resp;
            err   <= to_resp && !legal;
            rd_ok <= to_resp && legal && !s_wen;
            if (state == IDLE) begin
                if (req) begin
                    c_wen   <= wen;
                    c_addr  <= addr;
                    c_wdata <= wdata;
                    cnt     <= 4'(LATENCY > 1 ? LATENCY - 2 : 0);
                    state   <= LATENCY == 1 ? RESP : BUSY;
                end
            end else if (state == BUSY) begin
                state <= cnt == 4'd0 ? RESP : BUSY;
                cnt   <= cnt == 4'd0 ? cnt : cnt - 4'd1;
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter WORD_DEPTH, default 36, number of 32-bit words stored.
REQ-002 Parameter BASE_ADDR, default 32'h10010000, byte address of word 0.
REQ-003 Parameter LATENCY, default 4, legal range 1..15, cycles from request acceptance to response.
REQ-004 Reset is asynchronous and active-low. The block has one clock.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req  input  1  the initiator holds a request pending.
REQ-008 wen  input  1  1 = write, 0 = read; sampled with req.
REQ-009 addr  input  32  byte address; sampled with req.
REQ-010 wdata  input  32  write data; sampled with req.
REQ-011 ready  output  1  one-cycle pulse marking response completion.
REQ-012 rdata  output  32  read data; valid only while ready=1.
REQ-013 err  output  1  asserted with ready when the captured request was illegal.

Function
REQ-014 The state machine SHALL have three states: IDLE, BUSY and RESP.
REQ-015 In IDLE with req=1 at a rising edge, the block SHALL capture wen, addr and wdata and go to BUSY. If LATENCY=1 it SHALL go directly to RESP.
REQ-016 On entry to BUSY, a 4-bit down-counter SHALL load LATENCY-2. BUSY SHALL decrement it each cycle. When the count is 0, the next state SHALL be RESP.
REQ-017 Net latency SHALL be exactly LATENCY cycles: the acceptance edge at cycle 0 gives ready=1 during cycle LATENCY.
REQ-018 The block SHALL stay in RESP for exactly one cycle and then return to IDLE unconditionally.
REQ-019 In BUSY and RESP, req, wen, addr and wdata SHALL be ignored. There is no queuing.
REQ-020 A request held continuously SHALL be re-accepted only from IDLE. This leaves a one-cycle bubble between back-to-back responses.
REQ-021 Legal request:
  - addr[1:0]==0
  - addr>=BASE_ADDR
  - (addr-BASE_ADDR)>>2 < WORD_DEPTH
REQ-022 The word index SHALL be (addr-BASE_ADDR)>>2, computed at 32-bit width with no wrap-around. An address below BASE_ADDR is illegal.
REQ-023 For a legal write, the word SHALL be written on the edge that enters RESP. rdata SHALL be 0 during that RESP cycle.
REQ-024 For a legal read, rdata SHALL be registered on the edge that enters RESP and hold the stored word.
REQ-025 For an illegal request: err=1 in RESP, no storage update, rdata=0.
REQ-026 Outside RESP: ready=0, err=0, rdata=0.
REQ-027 All outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-028 The storage array SHALL be exposed hierarchically as mem[0:WORD_DEPTH-1] so the bench can preload and inspect it.

Reset
REQ-029 rst_n=0 SHALL immediately force:
  - state=IDLE, counter=0
  - ready=0, err=0, rdata=0
  - captured request fields = 0
REQ-030 Reset SHALL NOT clear the storage array.
REQ-031 Reset asserted during BUSY SHALL abandon the request: no write and no ready pulse.
REQ-032 After reset deasserts, the first acceptance SHALL occur on the first rising edge with req=1.

Structure
REQ-033 A shared package dmem_pkg SHALL hold:
  - the state encoding IDLE=2'd0, BUSY=2'd1, RESP=2'd2
  - the default BASE_ADDR, WORD_DEPTH and LATENCY constants
REQ-034 The storage SHALL be one sub-module, dmem_array:
  - one synchronous write port
  - one synchronous read port
  - no reset
  - instantiated as u_array
REQ-035 The state machine, counter and legality check SHALL stay in dmem_responder.

Verification
REQ-036 Write 0xDEADBEEF to 0x10010004 (default parameters), accepted at cycle 0 -> ready=1, err=0 at cycle 4; mem[1]=0xDEADBEEF afterwards; a later read of the same address returns rdata=0xDEADBEEF with ready at acceptance+4.
REQ-037 Read from 0x10010090 (index 36, just out of range) -> ready=1, err=1, rdata=0 at cycle 4; read from 0x1001008C -> err=0 and returns mem[35].
REQ-038 Write to 0x10010002 (misaligned) or to 0x1000FFFC (below base) -> err=1 with ready; all 36 words unchanged.
REQ-039 req held high for 20 cycles, alternating write/read -> ready pulses exactly every LATENCY+1=5 cycles; ready is never high two cycles in a row.
REQ-040 rst_n pulsed low 2 cycles into a write of 0x12345678 to 0x10010000 -> outputs 0 immediately; no ready pulse; mem[0] keeps its preloaded value; the next request completes normally.
REQ-041 LATENCY=1 instance: read of 0x10010008 accepted at cycle 0 -> ready=1 at cycle 1 with mem[2]; next acceptance at cycle 2.
